fifo_byte_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_byte_packer_out_reg.sv | 52 +++++
 rtl/fifo_byte_packer.sv | 118 +++++++++++
 tb/tb_fifo_byte_packer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO byte packer.
// Holds the fixed data widths, the packer FSM state type and byte-keep helpers.
package fifo_pkg;

    localparam int FIFO_DW        = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int PACK_WORD_W    = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int RD_LATENCY     = 1;

    typedef enum logic {
        S_FILL,
        S_FLUSH
    } packer_state_t;

    // Keep mask with the low 'cnt' bytes set; cnt==4 yields 4'b1111.
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [2:0] cnt);
        logic [BYTES_PER_WORD:0] m;
        m = (5'd1 << cnt) - 5'd1;
        return m[BYTES_PER_WORD-1:0];
    endfunction

    function automatic logic [PACK_WORD_W-1:0] keep_to_bits(input logic [BYTES_PER_WORD-1:0] keep);
        logic [PACK_WORD_W-1:0] bits;
        bits = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            bits[8*k +: 8] = {8{keep[k]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_byte_packer_out_reg.sv
// Output holding register for the byte packer (valid/ready, no skid buffer).
// Loads only when free, i.e. empty or being accepted in the same cycle.
module pack_out_reg
    import fifo_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      load_i,
    input  logic [PACK_WORD_W-1:0]    data_i,
    input  logic [BYTES_PER_WORD-1:0] keep_i,
    input  logic                      ready_i,
    output logic                      free_o,
    output logic                      valid_o,
    output logic [PACK_WORD_W-1:0]    data_o,
    output logic [BYTES_PER_WORD-1:0] keep_o
);

    logic                      valid_q, valid_d;
    logic [PACK_WORD_W-1:0]    data_q, data_d;
    logic [BYTES_PER_WORD-1:0] keep_q, keep_d;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains an 8-bit FIFO and packs bytes little-endian into 32-bit words with a flush path.
// Optional `PACKER_WORD_CNT_EN adds word_cnt_o counting accepted output words.
module fifo_byte_packer
    import fifo_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      fifo_empty_i,
    input  logic [FIFO_DW-1:0]        fifo_rdata_i,
    output logic                      fifo_rd_en_o,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PACK_WORD_W-1:0]    out_data_o,
    output logic [BYTES_PER_WORD-1:0] out_keep_o
`ifdef PACKER_WORD_CNT_EN
    ,
    output logic [15:0]               word_cnt_o
`endif
);

    packer_state_t             state_q, state_d;
    logic [PACK_WORD_W-1:0]    asm_data_q, asm_data_d;
    logic [2:0]                asm_cnt_q, asm_cnt_d;
    logic                      rd_pending_q, rd_pending_d;
    logic [2:0]                in_flight;
    logic [2:0]                cnt_base;
    logic                      out_free;
    logic                      out_load;
    logic [PACK_WORD_W-1:0]    load_data;
    logic [BYTES_PER_WORD-1:0] load_keep;

    assign in_flight    = asm_cnt_q + {2'b00, rd_pending_q};
    assign fifo_rd_en_o = (state_q == S_FILL) && !fifo_empty_i && (in_flight < 3'(BYTES_PER_WORD));
    assign rd_pending_d = fifo_rd_en_o;

    // cnt_base is the lane count after any transfer, so a capture on the
    // transfer edge lands in lane 0 of the fresh word.
    always_comb begin
        state_d    = state_q;
        asm_data_d = asm_data_q;
        cnt_base   = asm_cnt_q;
        out_load   = 1'b0;
        load_data  = asm_data_q;
        load_keep  = {BYTES_PER_WORD{1'b1}};
        unique case (state_q)
            S_FILL: begin
                if (asm_cnt_q == 3'(BYTES_PER_WORD) && out_free) begin
                    out_load = 1'b1;
                    cnt_base = 3'd0;
                end
                if (flush_i && in_flight != 3'd0) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!rd_pending_q && out_free) begin
                    if (asm_cnt_q != 3'd0) begin
                        out_load  = 1'b1;
                        load_keep = keep_mask(asm_cnt_q);
                        load_data = asm_data_q & keep_to_bits(keep_mask(asm_cnt_q));
                    end
                    cnt_base = 3'd0;
                    state_d  = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        asm_cnt_d = cnt_base;
        if (rd_pending_q) begin
            asm_data_d[{cnt_base[1:0], 3'b000} +: 8] = fifo_rdata_i;
            asm_cnt_d = cnt_base + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_FILL;
            asm_data_q   <= '0;
            asm_cnt_q    <= 3'd0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            asm_data_q   <= asm_data_d;
            asm_cnt_q    <= asm_cnt_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    pack_out_reg u_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (out_load),
        .data_i  (load_data),
        .keep_i  (load_keep),
        .ready_i (out_ready_i),
        .free_o  (out_free),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .keep_o  (out_keep_o)
    );

`ifdef PACKER_WORD_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    assign word_cnt_d = (out_valid_o && out_ready_i) ? word_cnt_q + 16'd1 : word_cnt_q;
    assign word_cnt_o = word_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q <= 16'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: behavioural FIFO, byte-list word model, decoupled monitor.
// Build with +define+PACKER_WORD_CNT_EN to also check word_cnt_o.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifoEmpty;
    logic [7:0]  fifoRdata;
    logic        rdEn;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [3:0]  outKeep;
`ifdef PACKER_WORD_CNT_EN
    logic [15:0] wordCnt;
`endif

    logic [7:0]  fifoQ[$];
    logic [7:0]  modelBytes[$];
    logic [35:0] expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;
    bit          randomReady = 1'b0;
    bit          held = 1'b0;
    logic [35:0] heldWord;

    always #5 clk = ~clk;

    fifo_byte_packer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_empty_i (fifoEmpty),
        .fifo_rdata_i (fifoRdata),
        .fifo_rd_en_o (rdEn),
        .flush_i      (flush),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_data_o   (outData),
        .out_keep_o   (outKeep)
`ifdef PACKER_WORD_CNT_EN
        ,
        .word_cnt_o   (wordCnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: bytes accumulate in arrival order, every 4 form a word,
    // a flush turns whatever remains into a partial word.
    task automatic modelPush(input logic [7:0] b);
        modelBytes.push_back(b);
        if (modelBytes.size() == 4) begin
            expQ.push_back({4'hF, modelBytes[3], modelBytes[2], modelBytes[1], modelBytes[0]});
            modelBytes.delete();
        end
    endtask

    task automatic modelFlush();
        logic [31:0] w;
        logic [3:0]  k;
        w = '0;
        k = '0;
        if (modelBytes.size() > 0) begin
            for (int i = 0; i < modelBytes.size(); i++) begin
                w[8*i +: 8] = modelBytes[i];
                k[i] = 1'b1;
            end
            expQ.push_back({k, w});
            modelBytes.delete();
        end
    endtask

    // Upstream FIFO model: registered read data, one cycle after rd_en.
    always @(posedge clk) begin
        if (rdEn && fifoQ.size() > 0) begin
            fifoRdata <= fifoQ.pop_front();
            fifoEmpty <= (fifoQ.size() == 0);
        end
    end

    always @(posedge clk) begin
        if (randomReady) begin
            #1;
            outReady = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: sample mid-cycle, compare each accepted word with the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (rdEn) checkOutput("rd_en_while_empty", 64'(fifoEmpty), 64'd0);
            if (held) checkOutput("hold_stable", {27'd0, outValid, outKeep, outData}, {27'd0, 1'b1, heldWord});
            if (outValid && outReady) begin
                handshakes++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %0h expected none", {outKeep, outData});
                end else begin
                    checkOutput("word", 64'({outKeep, outData}), 64'(expQ.pop_front()));
                end
            end
            held = outValid && !outReady;
            heldWord = {outKeep, outData};
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        while (fifoQ.size() >= 16 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) failNow("fifo_space");
        fifoQ.push_back(b);
        fifoEmpty = 1'b0;
        modelPush(b);
        @(posedge clk); #1;
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        modelFlush();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic waitDrained(input int budget);
        int c = 0;
        while (fifoQ.size() != 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) failNow("drain_timeout");
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while ((fifoQ.size() != 0 || expQ.size() != 0 || outValid) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) failNow("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] dirBytes[8];
        int         count;
        int         r;

        rst_n     = 1'b0;
        flush     = 1'b0;
        outReady  = 1'b0;
        fifoEmpty = 1'b1;
        fifoRdata = 8'h00;
        #12;
        checkOutput("reset_rd_en", 64'(rdEn), 64'd0);
        checkOutput("reset_valid", 64'(outValid), 64'd0);
        checkOutput("reset_data", 64'(outData), 64'd0);
        checkOutput("reset_keep", 64'(outKeep), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] eight bytes, ready high");
        outReady = 1'b1;
        dirBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) applyStimulus(dirBytes[i]);
        waitIdle(200);

        $display("[TB] three bytes then flush");
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        waitDrained(100);
        pulseFlush();
        waitIdle(200);

        $display("[TB] backpressure with 16 bytes");
        outReady = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i * 13 + 7));
        repeat (40) begin
            @(posedge clk); #1;
        end
        checkOutput("stall_valid", 64'(outValid), 64'd1);
        checkOutput("stall_word", 64'({outKeep, outData}), 64'(expQ[0]));
        checkOutput("stall_fifo_level", 64'(fifoQ.size()), 64'd8);
        checkOutput("stall_rd_en", 64'(rdEn), 64'd0);
        checkOutput("stall_pending_words", 64'(expQ.size()), 64'd4);
        outReady = 1'b1;
        waitIdle(300);

        $display("[TB] flush on the read of byte 2");
        fifoQ.push_back(8'h5A);
        modelPush(8'h5A);
        fifoQ.push_back(8'h6B);
        modelPush(8'h6B);
        fifoEmpty = 1'b0;
        count = 0;
        r = 0;
        while (count < 2 && r < 20) begin
            @(negedge clk);
            if (rdEn) count++;
            r++;
        end
        if (count < 2) failNow("byte2_read");
        flush = 1'b1;
        checkOutput("flush_word_model", 64'(modelBytes.size()), 64'd2);
        modelFlush();
        @(posedge clk); #1;
        flush = 1'b0;
        waitIdle(200);

        $display("[TB] flush with nothing held");
        pulseFlush();
        for (int i = 0; i < 10; i++) begin
            checkOutput("ignored_flush_valid", 64'(outValid), 64'd0);
            @(posedge clk); #1;
        end

        $display("[TB] randomized traffic");
        randomReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                waitDrained(2000);
                pulseFlush();
            end else if (r < 14) begin
                applyStimulus(8'($urandom));
            end else begin
                @(posedge clk); #1;
            end
        end
        randomReady = 1'b0;
        @(posedge clk); #1;
        outReady = 1'b1;
        waitDrained(2000);
        pulseFlush();
        waitIdle(1000);

        $display("[TB] reset mid-word");
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        waitDrained(100);
        checkOutput("pre_reset_no_words", 64'(expQ.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(outValid), 64'd0);
        checkOutput("midreset_data", 64'(outData), 64'd0);
        checkOutput("midreset_keep", 64'(outKeep), 64'd0);
        checkOutput("midreset_rd_en", 64'(rdEn), 64'd0);
        modelBytes.delete();
        handshakes = 0;
`ifdef PACKER_WORD_CNT_EN
        checkOutput("midreset_word_cnt", 64'(wordCnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
        waitIdle(200);

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
`ifdef PACKER_WORD_CNT_EN
        checkOutput("word_cnt", 64'(wordCnt), 64'(handshakes));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
